// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer. It walks an NWORDS*WORD_W operand pair
// through one shared WORD_W-bit combinational adder, one word per cycle, starting
// with the LS word. The carry is chained from word to word, and the finished
// result is returned over a valid/ready response handshake.
module mp_add_sequencer #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 4,
  localparam int W     = NWORDS * WORD_W,
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [W-1:0]      req_a,
  input  logic [W-1:0]      req_b,
  input  logic              req_op,
  input  logic              req_cin,
  output logic [WORD_W-1:0] add_a,
  output logic [WORD_W-1:0] add_b,
  output logic              add_cin,
  input  logic [WORD_W-1:0] add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     beff_q, beff_d;   // operand B, already inverted for subtract
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Handshake outputs: responses are hidden while reset is held.
  always_comb begin
    req_ready = (state_q == IDLE) && !rst;
    rsp_valid = (state_q == DONE) && !rst;
    rsp_sum   = sum_q;
    rsp_cout  = cout_q;
    rsp_ovf   = ovf_q;
  end

  // Adder operand drive: the current word while running, zeros otherwise.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if ((state_q == RUN) && !rst) begin
      add_a   = a_q[idx_q*WORD_W +: WORD_W];
      add_b   = beff_q[idx_q*WORD_W +: WORD_W];
      add_cin = carry_q;
    end else begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
    end
  end

  // Next-state logic: capture at accept, fold one word per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    beff_d  = beff_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          beff_d  = req_op ? ~req_b : req_b;
          carry_d = req_op ? 1'b1 : req_cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*WORD_W +: WORD_W] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          // Signed overflow: both operands share a sign but the result does not.
          ovf_d   = (a_q[W-1] == beff_q[W-1]) && (add_sum[WORD_W-1] != a_q[W-1]);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset also wipes any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      beff_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      beff_q  <= beff_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer. A behavioural 32-bit adder sits on the
// add_* port. An arithmetic reference model predicts every output on each cycle,
// and directed cases pin the model against hand-computed results.
module tb_mp_add_sequencer;
  localparam int WORD_W = 32;
  localparam int NWORDS = 4;
  localparam int W      = NWORDS * WORD_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [W-1:0]      req_a;
  logic [W-1:0]      req_b;
  logic              req_op;
  logic              req_cin;
  logic [WORD_W-1:0] add_a;
  logic [WORD_W-1:0] add_b;
  logic              add_cin;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              rsp_ovf;

  int n_checks = 0;
  int n_err    = 0;

  mp_add_sequencer #(.WORD_W(WORD_W), .NWORDS(NWORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural combinational word adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WORD_W{1'b0}}, add_cin};

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [W-1:0] ref_sum(input logic [W-1:0] a, b, input logic op, cin);
    if (op) return a - b;
    else    return a + b + W'(cin);
  endfunction

  function automatic logic ref_cout(input logic [W-1:0] a, b, input logic op, cin);
    logic [W:0] t;
    if (op) return (a >= b);
    t = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    return t[W];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic op, cin);
    logic [W:0] sa, sb, r;
    sa = {a[W-1], a};
    sb = {b[W-1], b};
    if (op) r = sa - sb;
    else    r = sa + sb + (W+1)'(cin);
    return r[W] != r[W-1];
  endfunction

  // Carry entering word w: the carry out of the sum of all lower words.
  function automatic logic carry_in(input logic [W-1:0] a, beff, input logic c0, input int w);
    logic [W-1:0] mask;
    logic [W:0]   p;
    if (w == 0) return c0;
    mask = {W{1'b1}} >> (W - w*WORD_W);
    p = {1'b0, a & mask} + {1'b0, beff & mask} + (W+1)'(c0);
    return p[w*WORD_W];
  endfunction

  // ---------------- reference model ----------------
  logic [W-1:0] m_a, m_beff, m_exp_sum, m_sum;
  logic         m_c0, m_exp_cout, m_exp_ovf, m_cout, m_ovf;
  int           m_busy = 0;   // words still to be processed
  bit           m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else if (m_done) begin
      if (rsp_ready) m_done <= 1'b0;
    end else if (m_busy > 0) begin
      m_sum[(NWORDS-m_busy)*WORD_W +: WORD_W] <= m_exp_sum[(NWORDS-m_busy)*WORD_W +: WORD_W];
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_done <= 1'b1;
        m_cout <= m_exp_cout;
        m_ovf  <= m_exp_ovf;
      end
    end else if (req_valid) begin
      m_a        <= req_a;
      m_beff     <= req_op ? ~req_b : req_b;
      m_c0       <= req_op ? 1'b1 : req_cin;
      m_exp_sum  <= ref_sum(req_a, req_b, req_op, req_cin);
      m_exp_cout <= ref_cout(req_a, req_b, req_op, req_cin);
      m_exp_ovf  <= ref_ovf(req_a, req_b, req_op, req_cin);
      m_busy     <= NWORDS;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int w;
    chk("req_ready", W'(req_ready), W'(!rst && m_busy == 0 && !m_done));
    chk("rsp_valid", W'(rsp_valid), W'(!rst && m_done));
    chk("rsp_sum", rsp_sum, m_sum);
    if (!rst && m_done) begin
      chk("rsp_cout", W'(rsp_cout), W'(m_cout));
      chk("rsp_ovf", W'(rsp_ovf), W'(m_ovf));
    end
    if (!rst && m_busy > 0) begin
      w = NWORDS - m_busy;
      chk("add_a", W'(add_a), W'(m_a[w*WORD_W +: WORD_W]));
      chk("add_b", W'(add_b), W'(m_beff[w*WORD_W +: WORD_W]));
      chk("add_cin", W'(add_cin), W'(carry_in(m_a, m_beff, m_c0, w)));
    end else begin
      chk("add_idle", W'({add_a, add_b, add_cin}), '0);
    end
  end

  // ---------------- directed helpers ----------------
  logic [3:0] cin_seq;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [W-1:0] a, b, input logic op, cin, input int hold,
                        input logic [W-1:0] esum, input logic ecout, eovf);
    int cyc;
    logic [W-1:0] held;
    req_a = a; req_b = b; req_op = op; req_cin = cin; req_valid = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 20) begin tick(); cyc++; end
    chk("accept_ready", W'(req_ready), W'(1));
    tick();                       // accept edge
    req_valid = 1'b0;
    req_a = {$urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom};
    req_op = ~op; req_cin = ~cin;
    cyc = 0; cin_seq = '0;
    while (!rsp_valid && cyc < 20) begin
      if (cyc < 4) cin_seq[cyc] = add_cin;
      tick();
      cyc++;
    end
    chk("latency", W'(cyc), W'(NWORDS));
    chk("lit_sum", rsp_sum, esum);
    chk("lit_cout", W'(rsp_cout), W'(ecout));
    chk("lit_ovf", W'(rsp_ovf), W'(eovf));
    held = rsp_sum;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_a = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk("hold_sum", rsp_sum, held);
      chk("hold_ready", W'(req_ready), W'(0));
      chk("hold_valid", W'(rsp_valid), W'(1));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("back_idle", W'(req_ready), W'(1));
    chk("back_novalid", W'(rsp_valid), W'(0));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return {W{1'b1}};
      1:       return {1'b0, {(W-1){1'b1}}};
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return W'($urandom_range(0, 9));
      default: return {$urandom, $urandom, $urandom, $urandom};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ones, max_pos, min_neg;
    ones    = {W{1'b1}};
    max_pos = {1'b0, {(W-1){1'b1}}};
    min_neg = {1'b1, {(W-1){1'b0}}};

    // Reset held with a pending request.
    rst = 1'b1; req_valid = 1'b1; rsp_ready = 1'b0;
    req_a = {32'h0, {96{1'b1}}}; req_b = W'(1); req_op = 1'b0; req_cin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ready", W'(req_ready), W'(0));
      chk("rst_valid", W'(rsp_valid), W'(0));
      chk("rst_add", W'({add_a, add_b, add_cin}), '0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_ready", W'(req_ready), W'(1));

    // Carry ripples across three words.
    run_op({32'h0, {96{1'b1}}}, W'(1), 1'b0, 1'b0, 0, {32'h1, 96'h0}, 1'b0, 1'b0);
    chk("cin_seq", W'(cin_seq), W'(4'b1110));

    // Add boundaries.
    run_op(ones, '0, 1'b0, 1'b1, 0, '0, 1'b1, 1'b0);
    run_op(max_pos, W'(1), 1'b0, 1'b0, 5, min_neg, 1'b0, 1'b1);

    // Subtract.
    run_op(W'(5), W'(7), 1'b1, 1'b1, 0, {{(W-2){1'b1}}, 2'b10}, 1'b0, 1'b0);
    run_op(max_pos, min_neg, 1'b1, 1'b0, 2, ones, 1'b0, 1'b1);

    // Reset while idx==2 in RUN aborts the operation.
    req_a = W'(100); req_b = W'(200); req_op = 1'b0; req_cin = 1'b0; req_valid = 1'b1;
    tick();                       // accept
    req_valid = 1'b0;
    tick();                       // word 0 done
    tick();                       // word 1 done, now on word 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("abort_valid", W'(rsp_valid), W'(0));
      chk("abort_sum", rsp_sum, '0);
      tick();
    end
    run_op(W'(3), W'(4), 1'b0, 1'b0, 0, W'(7), 1'b0, 1'b0);

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_a     = pick_operand();
      req_b     = pick_operand();
      req_op    = $urandom_range(0, 1) == 1;
      req_cin   = $urandom_range(0, 1) == 1;
      rsp_ready = ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 60) == 0);
      tick();
    end
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
